// File: rtl/switch_conditioner_if.sv
// Switch conditioner bus: raw switch inputs and frame tick in, conditioned levels and pulses out.
interface switch_conditioner_if #(
    parameter int WIDTH = 8
);
    logic             tick;
    logic [WIDTH-1:0] switches_raw;
    logic [WIDTH-1:0] switches;
    logic [WIDTH-1:0] pressed;
    logic [WIDTH-1:0] released;
    logic [WIDTH-1:0] repeat_pulse;

    modport master (
        output tick, switches_raw,
        input  switches, pressed, released, repeat_pulse
    );

    modport slave (
        input  tick, switches_raw,
        output switches, pressed, released, repeat_pulse
    );
endinterface

// File: rtl/switch_conditioner.sv
// Per-player switch synchroniser, debouncer and press/release edge generator.
// Optional frame-tick auto-repeat is built when SWITCH_CONDITIONER_REPEAT_EN is defined.
module switch_conditioner_lane #(
    parameter int DEBOUNCE_CYCLES = 1024
`ifdef SWITCH_CONDITIONER_REPEAT_EN
    ,
    parameter int REPEAT_DELAY    = 30,
    parameter int REPEAT_PERIOD   = 6
`endif
) (
    input  logic clk,
    input  logic reset,
`ifdef SWITCH_CONDITIONER_REPEAT_EN
    input  logic tick,
`endif
    input  logic raw,
    output logic level,
    output logic press,
    output logic rel,
    output logic rpt
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic          s1, s2;
    logic [CW-1:0] cnt;
    logic          accept;

    // A differing sample on the last count slot commits the new level.
    assign accept = (s2 != level) && (cnt == CW'(DEBOUNCE_CYCLES - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1    <= 1'b0;
            s2    <= 1'b0;
            level <= 1'b0;
            press <= 1'b0;
            rel   <= 1'b0;
            cnt   <= '0;
        end else begin
            s1    <= raw;
            s2    <= s1;
            press <= accept & s2;
            rel   <= accept & ~s2;
            if (accept)
                level <= s2;
            if (s2 == level || accept)
                cnt <= '0;
            else
                cnt <= cnt + 1'b1;
        end
    end

`ifdef SWITCH_CONDITIONER_REPEAT_EN
    logic [7:0] rc;
    logic       first;
    logic [7:0] target;

    assign target = first ? 8'(REPEAT_DELAY) : 8'(REPEAT_PERIOD);

    // Release acceptance wins over a coincident tick so no pulse lands on the falling cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rc    <= '0;
            first <= 1'b0;
            rpt   <= 1'b0;
        end else begin
            rpt <= 1'b0;
            if (accept && !s2) begin
                rc    <= '0;
                first <= 1'b0;
            end else if (press) begin
                rc    <= '0;
                first <= 1'b1;
            end else if (level && tick) begin
                if (rc + 8'd1 == target) begin
                    rpt   <= 1'b1;
                    rc    <= '0;
                    first <= 1'b0;
                end else begin
                    rc <= rc + 8'd1;
                end
            end
        end
    end
`else
    assign rpt = 1'b0;
`endif
endmodule

module switch_conditioner #(
    parameter int WIDTH           = 8,
    parameter int DEBOUNCE_CYCLES = 1024,
    parameter int REPEAT_DELAY    = 30,
    parameter int REPEAT_PERIOD   = 6
) (
    input  logic                  clk,
    input  logic                  reset,
    switch_conditioner_if.slave   sc
);
    logic [WIDTH-1:0] level, press, rel, rpt;

    for (genvar i = 0; i < WIDTH; i++) begin : g_lane
        switch_conditioner_lane #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
`ifdef SWITCH_CONDITIONER_REPEAT_EN
            ,
            .REPEAT_DELAY    (REPEAT_DELAY),
            .REPEAT_PERIOD   (REPEAT_PERIOD)
`endif
        ) u_lane (
            .clk   (clk),
            .reset (reset),
`ifdef SWITCH_CONDITIONER_REPEAT_EN
            .tick  (sc.tick),
`endif
            .raw   (sc.switches_raw[i]),
            .level (level[i]),
            .press (press[i]),
            .rel   (rel[i]),
            .rpt   (rpt[i])
        );
    end

    assign sc.switches     = level;
    assign sc.pressed      = press;
    assign sc.released     = rel;
    assign sc.repeat_pulse = rpt;
endmodule

// File: tb/tb_switch_conditioner.sv
// Scoreboard bench for switch_conditioner: expected events queued at stimulus, checked when pulses appear.
module tb_switch_conditioner;
    localparam int W   = 8;
    localparam int DBC = 4;
    localparam int RD  = 3;
    localparam int RP  = 2;
    localparam int LAT = 2 + DBC;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   cyc   = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    typedef struct {
        int         due;
        logic [7:0] sw;
        logic [7:0] pr;
        logic [7:0] rl;
        logic [7:0] rp;
    } exp_t;

    exp_t       q[$];
    exp_t       e;
    logic [7:0] model_sw;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    switch_conditioner_if #(.WIDTH(W)) bus ();

    switch_conditioner #(
        .WIDTH           (W),
        .DEBOUNCE_CYCLES (DBC),
        .REPEAT_DELAY    (RD),
        .REPEAT_PERIOD   (RP)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .sc    (bus.slave)
    );

    // Scoreboard side: every pulse cycle must match the oldest expected event.
    always @(negedge clk) begin
        if (!reset && (|bus.pressed || |bus.released || |bus.repeat_pulse)) begin
            n_cmp++;
            if (q.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_pulse: got pr=%h rl=%h rp=%h sw=%h, required no pulse",
                         bus.pressed, bus.released, bus.repeat_pulse, bus.switches);
            end else begin
                e = q.pop_front();
                if ({bus.switches, bus.pressed, bus.released, bus.repeat_pulse} !== {e.sw, e.pr, e.rl, e.rp}) begin
                    n_bad++;
                    $display("FAIL sb_event: got sw=%h pr=%h rl=%h rp=%h, required sw=%h pr=%h rl=%h rp=%h",
                             bus.switches, bus.pressed, bus.released, bus.repeat_pulse, e.sw, e.pr, e.rl, e.rp);
                end
                n_cmp++;
                if (cyc < e.due - 1 || cyc > e.due + 1) begin
                    n_bad++;
                    $display("FAIL sb_latency: got cycle %0d, required %0d +/-1", cyc, e.due);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, required finish");
        $fatal(1);
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_drain(output int left);
        for (int i = 0; i < 20 && q.size() != 0; i++) step(1);
        left = q.size();
    endtask

    // Called just after a clock edge; queues the accept event the new raw value should produce.
    task automatic drive_raw(input logic [7:0] v);
        exp_t x;
        x.due = cyc + LAT;
        x.sw  = v;
        x.pr  = v & ~model_sw;
        x.rl  = ~v & model_sw;
        x.rp  = 8'h00;
        bus.switches_raw = v;
        if ((x.pr | x.rl) != 8'h00) q.push_back(x);
        model_sw = v;
    endtask

    task automatic test_reset;
        exp_t x;
        int   left;
        bus.switches_raw = 8'hFF;
        #2 reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step(1);
            n_cmp++;
            if ({bus.switches, bus.pressed, bus.released, bus.repeat_pulse} !== 32'h0) begin
                n_bad++;
                $display("FAIL reset_outputs: got sw=%h pr=%h rl=%h rp=%h, required all 0",
                         bus.switches, bus.pressed, bus.released, bus.repeat_pulse);
            end
        end
        reset = 1'b0;
        x.due = cyc + LAT; x.sw = 8'hFF; x.pr = 8'hFF; x.rl = 8'h00; x.rp = 8'h00;
        q.push_back(x);
        model_sw = 8'hFF;
        wait_drain(left);
        n_cmp++;
        if (left !== 0) begin
            n_bad++;
            $display("FAIL reset_held_press: got %0d pending events, required 0", left);
        end
        step(3);
        drive_raw(8'h00);
        wait_drain(left);
        n_cmp++;
        if (left !== 0) begin
            n_bad++;
            $display("FAIL reset_all_release: got %0d pending events, required 0", left);
        end
        step(3);
    endtask

    task automatic test_press_release;
        int left;
        drive_raw(8'h10);
        wait_drain(left);
        n_cmp++;
        if (left !== 0) begin
            n_bad++;
            $display("FAIL press_bit4: got %0d pending events, required 0", left);
        end
        step(2);
        n_cmp++;
        if (bus.switches !== 8'h10) begin
            n_bad++;
            $display("FAIL hold_bit4: got sw=%h, required 10", bus.switches);
        end
        drive_raw(8'h00);
        wait_drain(left);
        n_cmp++;
        if (left !== 0) begin
            n_bad++;
            $display("FAIL release_bit4: got %0d pending events, required 0", left);
        end
        step(3);
    endtask

    task automatic test_bounce;
        bus.switches_raw = 8'h01; step(3);
        bus.switches_raw = 8'h00; step(1);
        bus.switches_raw = 8'h01; step(3);
        bus.switches_raw = 8'h00; step(12);
        n_cmp++;
        if (bus.switches !== 8'h00 || q.size() != 0) begin
            n_bad++;
            $display("FAIL bounce_bit0: got sw=%h pending=%0d, required sw=00 pending=0",
                     bus.switches, q.size());
        end
    endtask

    task automatic test_simultaneous;
        int left;
        drive_raw(8'h04);
        wait_drain(left);
        step(2);
        drive_raw(8'h02);
        wait_drain(left);
        n_cmp++;
        if (left !== 0 || bus.switches !== 8'h02) begin
            n_bad++;
            $display("FAIL simultaneous: got pending=%0d sw=%h, required pending=0 sw=02", left, bus.switches);
        end
        step(2);
        drive_raw(8'h00);
        wait_drain(left);
        n_cmp++;
        if (left !== 0) begin
            n_bad++;
            $display("FAIL simultaneous_release: got %0d pending events, required 0", left);
        end
        step(3);
    endtask

    task automatic test_reset_mid;
        exp_t x;
        int   left;
        drive_raw(8'h80);
        wait_drain(left);
        step(2);
        bus.switches_raw = 8'h88;
        step(4);
        #2 reset = 1'b1;
        #1;
        n_cmp++;
        if ({bus.switches, bus.pressed, bus.released, bus.repeat_pulse} !== 32'h0) begin
            n_bad++;
            $display("FAIL reset_mid_immediate: got sw=%h pr=%h rl=%h rp=%h, required all 0",
                     bus.switches, bus.pressed, bus.released, bus.repeat_pulse);
        end
        model_sw = 8'h00;
        step(2);
        reset = 1'b0;
        x.due = cyc + LAT; x.sw = 8'h88; x.pr = 8'h88; x.rl = 8'h00; x.rp = 8'h00;
        q.push_back(x);
        model_sw = 8'h88;
        wait_drain(left);
        n_cmp++;
        if (left !== 0) begin
            n_bad++;
            $display("FAIL reset_mid_restart: got %0d pending events, required 0", left);
        end
        step(2);
        drive_raw(8'h00);
        wait_drain(left);
        step(3);
    endtask

    task automatic test_repeat;
        exp_t x;
        int   left;
        drive_raw(8'h20);
        wait_drain(left);
        n_cmp++;
        if (left !== 0) begin
            n_bad++;
            $display("FAIL repeat_press: got %0d pending events, required 0", left);
        end
        for (int k = 1; k <= 8; k++) begin
            step(9);
            bus.tick = 1'b1;
`ifdef SWITCH_CONDITIONER_REPEAT_EN
            if (k == RD || (k > RD && ((k - RD) % RP) == 0)) begin
                x.due = cyc + 1; x.sw = 8'h20; x.pr = 8'h00; x.rl = 8'h00; x.rp = 8'h20;
                q.push_back(x);
            end
`endif
            step(1);
            bus.tick = 1'b0;
        end
        wait_drain(left);
        n_cmp++;
        if (left !== 0) begin
            n_bad++;
            $display("FAIL repeat_pulses: got %0d pending events, required 0", left);
        end
        drive_raw(8'h00);
        wait_drain(left);
        for (int k = 0; k < 4; k++) begin
            step(9);
            bus.tick = 1'b1;
            step(1);
            bus.tick = 1'b0;
        end
        step(3);
        n_cmp++;
        if (q.size() != 0 || bus.switches !== 8'h00) begin
            n_bad++;
            $display("FAIL repeat_after_release: got pending=%0d sw=%h, required pending=0 sw=00",
                     q.size(), bus.switches);
        end
    endtask

    initial begin
        bus.tick         = 1'b0;
        bus.switches_raw = 8'h00;
        model_sw         = 8'h00;
        test_reset;
        test_press_release;
        test_bounce;
        test_simultaneous;
        test_reset_mid;
        test_repeat;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/switch_conditioner.md
# switch_conditioner

Input conditioning stage between the raw `switches_p1` / `switches_p2` buses and the game top level. One instance per player. Each instance synchronises the 8 switch bits, debounces them, and produces a clean level per bit plus one-cycle press and release pulses. An optional per-bit auto-repeat, paced by a frame tick taken from the sync generator, emits repeat pulses while a switch stays held. Bit meaning (directions, fire) is not interpreted here; all bits are handled identically.

## Interface
- `WIDTH`, 8, number of switch bits conditioned.
- `DEBOUNCE_CYCLES`, 1024, consecutive post-sync clocks a new level must hold before it is accepted; legal range 1..65535.
- `REPEAT_DELAY`, 30, ticks from press to first repeat pulse; legal range 1..255.
- `REPEAT_PERIOD`, 6, ticks between later repeat pulses; legal range 1..255.

- `clk`  in  1  system clock, the same clock that drives the sync generator.
- `reset`  in  1  asynchronous, active-high reset.
- `tick`  in  1  one-cycle frame strobe, e.g. at vsync start; only used by auto-repeat.
- `switches_raw`  in  WIDTH  asynchronous switch inputs, 1 = pressed.
- `switches`  out  WIDTH  debounced level.
- `pressed`  out  WIDTH  one-cycle pulse on an accepted 0->1 transition.
- `released`  out  WIDTH  one-cycle pulse on an accepted 1->0 transition.
- `repeat_pulse`  out  WIDTH  one-cycle auto-repeat pulse.

## Operation
- Synchroniser: each bit passes through two flops, `s1` then `s2`. Both reset to 0.
- Debounce, per bit, with a counter `cnt` of width clog2(DEBOUNCE_CYCLES+1):
  - If `s2` == `switches[i]`, then `cnt` <= 0.
  - If they differ and `cnt` == DEBOUNCE_CYCLES-1, then:
    - `switches[i]` <= `s2`;
    - `cnt` <= 0;
    - `pressed[i]` or `released[i]` <= 1, according to the new level.
  - If they differ otherwise, `cnt` <= `cnt`+1.
- Any single sample in which `s2` equals the current level (a bounce) restarts the count from 0.
- `pressed` and `released` are registered. Each is high for exactly one clock, in the same cycle in which `switches` first shows the new level. A bit never has both high at once.
- Bits are fully independent. Several bits may change or pulse in the same cycle.
- Reset, including mid-count: every flop and counter clears immediately.
  - All outputs = 0.
  - A switch held through reset is accepted as a press after the normal latency once reset is released.

## Timing
- Raw edge to `switches` / pulse: 2 clocks of synchronisation plus DEBOUNCE_CYCLES clocks, with ±1 clock of uncertainty from asynchronous sampling.
- A raw pulse shorter than DEBOUNCE_CYCLES clocks, measured after synchronisation, is never accepted.
- With DEBOUNCE_CYCLES = 1, a change is accepted on the first post-sync sample that differs.
- `tick` is sampled as a level once per clock. The block makes no assumption about tick spacing.

## Configuration
- Macro `SWITCH_CONDITIONER_REPEAT_EN`.
- Defined, auto-repeat is active. Each bit has an 8-bit tick counter `rc` and a flag `first`.
  - On `pressed[i]`: `rc` <= 0 and `first` <= 1.
  - While `switches[i]` == 1 and `tick` == 1, `rc` increments.
  - When `rc` reaches REPEAT_DELAY with `first` = 1:
    - `repeat_pulse[i]` is high for 1 clock;
    - `rc` <= 0;
    - `first` <= 0.
  - Thereafter, each time `rc` reaches REPEAT_PERIOD: a 1-clock `repeat_pulse[i]`, and `rc` <= 0.
  - Release clears `rc` and `first` in the same cycle that `switches[i]` falls. No repeat pulse is emitted on or after release.
  - A tick that coincides with the press cycle is not counted.
- Undefined:
  - `repeat_pulse` is tied to 0 and no repeat counters are synthesised;
  - `tick` is ignored;
  - the REPEAT_* parameters have no effect.

## Test plan
The bench uses WIDTH = 8, DEBOUNCE_CYCLES = 4, REPEAT_DELAY = 3, REPEAT_PERIOD = 2.
- Reset: assert `reset` with `switches_raw` = 8'hFF.
  - Required: all outputs 0 during reset.
  - After release: `switches` = 8'hFF and `pressed` = 8'hFF (single cycle) within 6±1 clocks, and `released` stays 0.
- Clean press then release of bit 4:
  - `switches[4]` rises 6±1 clocks after the raw edge, with `pressed` = 8'h10 for exactly 1 clock.
  - Dropping the raw bit gives `released` = 8'h10 with the same latency.
- Bounce on bit 0: raw 1 for 3 clocks, 0 for 1 clock, 1 for 3 clocks, then 0.
  - Required: `switches` stays 0 and no pulses occur.
- Simultaneous events: bit 1 rises while bit 2 falls in the same clock.
  - Required: a single accept cycle showing `pressed` = 8'h02, `released` = 8'h04 and `switches` updated for both bits.
- Reset mid-debounce: assert `reset` 2 clocks into the count.
  - Required: outputs 0 immediately, and the count restarts from 0 after release.
- Repeat, with the macro defined: hold bit 5 and send one tick every 10 clocks.
  - Required: `repeat_pulse` = 8'h20 on the 3rd tick after `pressed`, then on every 2nd tick.
  - After release, no further `repeat_pulse` is produced.
  - With the macro undefined, `repeat_pulse` stays 0 throughout the same stimulus.
